sat_accum_stream: RTL and testbench

- Parametrised, sequential successor to the combinational saturating adder.
- Accumulates a stream of signed two's-complement terms into a saturating accumulator, one group at a time; a group is delimited by in_last.
- Presents each group's clamped sum, a sticky saturation flag and a term count on a valid/ready output port.
- Sits between a neuron's product stream and its activation stage.

---
 rtl/sat_accum_stream.sv | 103 ++++++++++
 tb/tb_sat_accum_stream.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_accum_stream.sv
// Saturating group accumulator: signed terms summed per in_last-delimited group, result registered one cycle after the last term.
// An unconsumed result drops in_ready, stalling upstream while the partial group stays intact.
module sat_accum_stream #(
  parameter int width       = 8,
  parameter int acc_width   = 8,
  parameter int count_width = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [width-1:0]       in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [acc_width-1:0]   out_data,
  output logic                   out_sat,
  output logic [count_width-1:0] out_count,
  input  logic                   out_ready
);

  localparam int ext_width = acc_width + 1;
  localparam logic signed [ext_width-1:0] sum_max = {2'b00, {(acc_width-1){1'b1}}};
  localparam logic signed [ext_width-1:0] sum_min = {2'b11, {(acc_width-1){1'b0}}};

  logic [acc_width-1:0]   acc;
  logic                   sticky;
  logic [count_width-1:0] count;
  logic                   first;

  logic                   accept;
  logic                   last_accept;
  logic signed [ext_width-1:0] base;
  logic signed [ext_width-1:0] term;
  logic signed [ext_width-1:0] sum;
  logic                   over;
  logic                   under;
  logic [acc_width-1:0]   acc_next;
  logic                   sticky_next;
  logic [count_width-1:0] count_next;

  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && in_last;

  // One extra bit of headroom makes a single add of two in-range values overflow-free.
  always_comb begin
    base  = first ? '0 : {acc[acc_width-1], acc};
    term  = {{(ext_width-width){in_data[width-1]}}, in_data};
    sum   = base + term;
    over  = sum > sum_max;
    under = sum < sum_min;

    if (over) begin
      acc_next = sum_max[acc_width-1:0];
    end else if (under) begin
      acc_next = sum_min[acc_width-1:0];
    end else begin
      acc_next = sum[acc_width-1:0];
    end

    sticky_next = (!first && sticky) || over || under;

    if (first) begin
      count_next = count_width'(1);
    end else if (&count) begin
      count_next = count;
    end else begin
      count_next = count + count_width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      sticky <= 1'b0;
      count  <= '0;
      first  <= 1'b1;
    end else if (accept) begin
      acc    <= acc_next;
      sticky <= sticky_next;
      count  <= count_next;
      first  <= in_last;
    end
  end

  // A new group result overwrites a result being consumed on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
    end else if (last_accept) begin
      out_valid <= 1'b1;
      out_data  <= acc_next;
      out_sat   <= sticky_next;
      out_count <= count_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sat_accum_stream.sv
// Bench for sat_accum_stream: two instances (8/8/8 and 8/12/2), queue scoreboard fed by a plain-arithmetic group model.
module tb_sat_accum_stream;

  typedef struct {
    longint data;
    bit     sat;
    int     count;
    bit     lat;
    int     cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        iv_a, il_a, ir_a, ov_a, os_a, ordy_a;
  logic [7:0]  id_a, od_a, oc_a;
  logic        iv_b, il_b, ir_b, ov_b, os_b, ordy_b;
  logic [7:0]  id_b;
  logic [11:0] od_b;
  logic [1:0]  oc_b;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   terms[2][64];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   done_a, done_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sat_accum_stream #(.width(8), .acc_width(8), .count_width(8)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv_a), .in_data(id_a), .in_last(il_a), .in_ready(ir_a),
    .out_valid(ov_a), .out_data(od_a), .out_sat(os_a), .out_count(oc_a), .out_ready(ordy_a)
  );

  sat_accum_stream #(.width(8), .acc_width(12), .count_width(2)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv_b), .in_data(id_b), .in_last(il_b), .in_ready(ir_b),
    .out_valid(ov_b), .out_data(od_b), .out_sat(os_b), .out_count(oc_b), .out_ready(ordy_b)
  );

  function automatic void chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic int s8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic drive(input int sel, input bit v, input int d, input bit l);
    if (sel == 0) begin
      iv_a = v; id_a = 8'(d); il_a = l;
    end else begin
      iv_b = v; id_b = 8'(d); il_b = l;
    end
  endtask

  // Called and returns at a falling edge; inputs change only there, handshakes sampled 1 before the rising edge.
  task automatic send_group(input int sel, input int n, input int bub, input bit lat);
    exp_t   e;
    longint s = 0;
    bit     st = 0;
    int     aw = (sel == 0) ? 8 : 12;
    int     cw = (sel == 0) ? 8 : 2;
    longint maxv = (longint'(1) << (aw - 1)) - 1;
    longint minv = -(longint'(1) << (aw - 1));
    for (int i = 0; i < n; i++) begin
      s += terms[sel][i];
      if (s > maxv) begin
        s = maxv; st = 1;
      end else if (s < minv) begin
        s = minv; st = 1;
      end
    end
    e.data  = s & ((longint'(1) << aw) - 1);
    e.sat   = st;
    e.count = (n > (1 << cw) - 1) ? (1 << cw) - 1 : n;
    e.lat   = lat;
    e.cyc   = 0;
    for (int i = 0; i < n; i++) begin
      int tmo = 0;
      bit done = 0;
      while (bub > 0 && $urandom_range(0, 99) < bub) begin
        drive(sel, 0, 0, 0);
        @(negedge clk);
      end
      drive(sel, 1, terms[sel][i], i == n - 1);
      while (!done) begin
        #4;
        if ((sel == 0) ? ir_a : ir_b) begin
          done = 1;
          if (i == n - 1) begin
            e.cyc = cyc + 1;
            if (sel == 0) exp_q0.push_back(e);
            else exp_q1.push_back(e);
          end
        end else if (++tmo > 300) begin
          checks++;
          failures++;
          $display("FAIL accept_timeout dut=%0d actual=stalled required=accepted", sel);
          done = 1;
        end
        @(negedge clk);
      end
    end
    drive(sel, 0, 0, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (reset_n && ov_a && ordy_a) begin
        if (exp_q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected actual=%0h required=no_output", od_a);
        end else begin
          e = exp_q0.pop_front();
          chk("a_data", longint'(od_a), e.data);
          chk("a_sat", longint'(os_a), longint'(e.sat));
          chk("a_count", longint'(oc_a), longint'(e.count));
          if (e.lat) chk("a_latency", longint'(cyc), longint'(e.cyc));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (reset_n && ov_b && ordy_b) begin
        if (exp_q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected actual=%0h required=no_output", od_b);
        end else begin
          e = exp_q1.pop_front();
          chk("b_data", longint'(od_b), e.data);
          chk("b_sat", longint'(os_b), longint'(e.sat));
          chk("b_count", longint'(oc_b), longint'(e.count));
          if (e.lat) chk("b_latency", longint'(cyc), longint'(e.cyc));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pa[8] = '{'h0F, 'h55, 'hC0, 'hBF, 'h00, 'h80, 'h7F, 'hAA};
    int pb[8] = '{'h0F, 'h55, 'hC0, 'hBF, 'h80, 'h00, 'h7F, 'hAA};
    int wait_cnt;

    reset_n = 1'b0;
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    ordy_a = 1'b1;
    ordy_b = 1'b1;
    repeat (2) @(negedge clk);
    #4;
    chk("rst_a_valid", longint'(ov_a), 0);
    chk("rst_a_data", longint'(od_a), 0);
    chk("rst_a_sat", longint'(os_a), 0);
    chk("rst_a_count", longint'(oc_a), 0);
    chk("rst_a_in_ready", longint'(ir_a), 1);
    chk("rst_b_valid", longint'(ov_b), 0);
    chk("rst_b_data", longint'(od_b), 0);
    chk("rst_b_count", longint'(oc_b), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Two-term pairs, including exact minimum and both rails.
    for (int i = 0; i < 8; i++) begin
      terms[0][0] = s8(pa[i]);
      terms[0][1] = s8(pb[i]);
      send_group(0, 2, 0, 1);
    end

    terms[0][0] = 127; terms[0][1] = 127; terms[0][2] = s8('h81);
    send_group(0, 3, 0, 1);

    for (int v = 1; v <= 3; v++) begin
      terms[0][0] = v;
      send_group(0, 1, 0, 1);
    end

    for (int i = 0; i < 3; i++) terms[1][i] = 127;
    send_group(1, 3, 0, 1);
    for (int i = 0; i < 5; i++) terms[1][i] = 1;
    send_group(1, 5, 0, 1);

    // Backpressure: result 0x30 held while the next group waits.
    repeat (3) @(negedge clk);
    ordy_a = 1'b0;
    terms[0][0] = 'h10; terms[0][1] = 'h20;
    send_group(0, 2, 0, 0);
    fork
      begin
        terms[0][0] = 1; terms[0][1] = 2; terms[0][2] = 3;
        send_group(0, 3, 0, 0);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          #4;
          chk("bp_in_ready", longint'(ir_a), 0);
          chk("bp_valid", longint'(ov_a), 1);
          chk("bp_data", longint'(od_a), 'h30);
          chk("bp_count", longint'(oc_a), 2);
          @(negedge clk);
        end
        ordy_a = 1'b1;
        @(negedge clk);
        ordy_a = 1'b0;
      end
    join
    #4;
    chk("bp2_valid", longint'(ov_a), 1);
    chk("bp2_data", longint'(od_a), 'h06);
    chk("bp2_in_ready", longint'(ir_a), 0);
    @(negedge clk);
    ordy_a = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a group.
    terms[0][0] = 'h22; terms[0][1] = 'h33;
    send_group(0, 2, 0, 1);
    drive(0, 1, 'h40, 0);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", longint'(ov_a), 0);
    chk("rst_mid_data", longint'(od_a), 0);
    chk("rst_mid_sat", longint'(os_a), 0);
    chk("rst_mid_count", longint'(oc_a), 0);
    drive(0, 0, 0, 0);
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    terms[0][0] = 5;
    send_group(0, 1, 0, 1);
    repeat (2) @(negedge clk);

    // Randomised groups with bubbles and random consumer stalls on both instances.
    done_a = 0;
    done_b = 0;
    fork
      begin
        for (int g = 0; g < 40; g++) begin
          int n = $urandom_range(1, 6);
          for (int i = 0; i < n; i++)
            terms[0][i] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 127 : -128)
                                                       : int'($urandom_range(0, 255)) - 128;
          send_group(0, n, 20, 0);
        end
        done_a = 1;
      end
      begin
        for (int g = 0; g < 40; g++) begin
          int n = $urandom_range(1, 7);
          for (int i = 0; i < n; i++)
            terms[1][i] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 127 : -128)
                                                       : int'($urandom_range(0, 255)) - 128;
          send_group(1, n, 20, 0);
        end
        done_b = 1;
      end
      begin
        while (!(done_a && done_b)) begin
          ordy_a = ($urandom_range(0, 3) != 0);
          ordy_b = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
        ordy_a = 1'b1;
        ordy_b = 1'b1;
      end
    join

    wait_cnt = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("drain_a_pending", longint'(exp_q0.size()), 0);
    chk("drain_b_pending", longint'(exp_q1.size()), 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
